// File: rtl/array_mcp_mask_ext.sv
// Single-port SRAM array model with a multicycle access protocol, per-lane write
// mask and a registered read-data output that holds until the next read completes.
module array_mcp_mask_ext #(
  parameter  int DATA_WIDTH = 512,
  parameter  int ADDR_WIDTH = 12,
  parameter  int DEPTH      = 4096,
  parameter  int MASK_GRAN  = 64,
  parameter  int MCP        = 2,
  localparam int MASK_W     = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst_n,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  input  logic [ADDR_WIDTH-1:0] RW0_addr,
  input  logic [MASK_W-1:0]     RW0_wmask,
  input  logic [DATA_WIDTH-1:0] RW0_wdata,
  output logic                  RW0_ready,
  output logic                  RW0_rvalid,
  output logic [DATA_WIDTH-1:0] RW0_rdata,
  output logic                  RW0_drop
);

  localparam logic [3:0]          CNT_LOAD = 4'(MCP - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  drop_q, drop_d;

  logic                  accept;
  logic                  wr_en;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign RW0_ready  = (cnt_q == 4'd0);
  assign RW0_rvalid = rvalid_q;
  assign RW0_rdata  = rdata_q;
  assign RW0_drop   = drop_q;

  assign accept = RW0_en && RW0_ready;
  assign wr_en  = accept && RW0_wmode && RW0_rst_n && ({1'b0, RW0_addr} < DEPTH_C);

  // A read completes on the edge where the busy count falls 1->0; with MCP=1
  // there is no busy phase, so it completes on the accept edge itself.
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    drop_d   = RW0_en && !RW0_ready;
    rd_fire  = 1'b0;
    rd_addr  = addr_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && !mode_q) rd_fire = 1'b1;
    end else if (RW0_en) begin
      cnt_d  = CNT_LOAD;
      addr_d = RW0_addr;
      mode_d = RW0_wmode;
      if (MCP == 1 && !RW0_wmode) begin
        rd_fire = 1'b1;
        rd_addr = RW0_addr;
      end
    end
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
    if (!RW0_rst_n) begin
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      mode_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      drop_q   <= drop_d;
    end
  end

  // Array contents are deliberately not reset; writes commit on the accept edge.
  always_ff @(posedge RW0_clk) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (RW0_wmask[i]) mem[RW0_addr][i*MASK_GRAN +: MASK_GRAN] <= RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

`ifdef RANDOMIZE_MEM_INIT
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < DATA_WIDTH; b++) mem[i][b] = 1'($random);
    end
  end
`endif

endmodule
